// File: rtl/melody_sequencer.sv
// Programmable note table player: issues one-cycle load strobes with a held
// frequency word to an audio_sample channel, spaced by per-note durations.
module melody_sequencer #(
  parameter int DEPTH    = 16,
  parameter int DUR_W    = 8,
  parameter int TICK_DIV = 781250
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [15:0]              wr_freq_i,
  input  logic [DUR_W-1:0]         wr_dur_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     loop_i,
  output logic                     en_o,
  output logic [15:0]              freq_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH)-1:0] idx_o,
  output logic                     done_o
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(DEPTH - 1);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  state_t            state;
  logic [15:0]       tbl_freq [DEPTH];
  logic [DUR_W-1:0]  tbl_dur  [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic [TICK_W-1:0] tick_cnt;
  logic [DUR_W-1:0]  dur_cnt;
  logic              end_pending;
  logic [15:0]       cur_freq;
  logic [DUR_W-1:0]  cur_dur;
  logic              finish;

  assign cur_freq = tbl_freq[idx];
  assign cur_dur  = tbl_dur[idx];
  assign busy_o   = (state != IDLE);
  assign idx_o    = idx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_freq[i] <= '0;
        tbl_dur[i]  <= '0;
      end
    end else if (wr_en_i) begin
      tbl_freq[wr_addr_i] <= wr_freq_i;
      tbl_dur[wr_addr_i]  <= wr_dur_i;
    end
  end

  // Stop wins over everything; a dur=0 entry ends unless a loop can restart at a nonzero index.
  always_comb begin
    finish = 1'b0;
    if (state == PLAY) begin
      finish = stop_i;
    end else if (state == LOAD) begin
      finish = stop_i || end_pending || ((cur_dur == '0) && !(loop_i && (idx != '0)));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      idx         <= '0;
      tick_cnt    <= '0;
      dur_cnt     <= '0;
      end_pending <= 1'b0;
      en_o        <= 1'b0;
      freq_o      <= '0;
      done_o      <= 1'b0;
    end else begin
      en_o   <= 1'b0;
      done_o <= 1'b0;
      if (finish) begin
        freq_o      <= '0;
        en_o        <= 1'b1;
        done_o      <= 1'b1;
        end_pending <= 1'b0;
        state       <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start_i && !stop_i) begin
              idx   <= '0;
              state <= LOAD;
            end
          end
          LOAD: begin
            if (cur_dur != '0) begin
              freq_o   <= cur_freq;
              en_o     <= 1'b1;
              dur_cnt  <= cur_dur;
              tick_cnt <= '0;
              state    <= PLAY;
            end else begin
              idx <= '0;
            end
          end
          PLAY: begin
            if (tick_cnt == TICK_MAX) begin
              tick_cnt <= '0;
              dur_cnt  <= dur_cnt - DUR_W'(1);
              if (dur_cnt == DUR_W'(1)) begin
                state <= LOAD;
                // Running off the table end still spends one LOAD cycle before the silence strobe.
                if (idx == IDX_MAX) begin
                  if (loop_i) idx <= '0;
                  else        end_pending <= 1'b1;
                end else begin
                  idx <= idx + IDX_W'(1);
                end
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
